spi_slave_byte: RTL and testbench
=================================

# spi_slave_byte

Receive-side SPI slave (mode-0 style, MSB first) that runs directly on the bus clock `clk`. While `cs` is low it shifts one `mosi` bit per rising edge of `clk`, and after every 8 bits it publishes the byte on `data_out`. On `miso` it echoes the previously completed byte, MSB first. It sits at the edge of the design, between an external SPI master and the register or command logic that consumes `data_out`.

## Interface
- `WIDTH`, default 8: frame length in bits; also the width of `data_out`.
- `clk` input 1: SPI/bus clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cs` input 1: chip select, active low.
- `mosi` input 1: serial data from the master, MSB first.
- `miso` output 1: serial data to the master, MSB first.
- `data_out` output `WIDTH`: last complete received frame.
- Port order is fixed: `clk`, `rst`, `cs`, `mosi`, `miso`, `data_out`.

## Operation
- **Reset** (`rst`=1 at a rising edge): `rx_shift`, `bit_cnt`, `tx_shift` and `data_out` all clear to 0. `miso` reads 0. Reset overrides `cs` and `mosi`.
- **Idle** (`cs`=1):
  - `bit_cnt` is forced to 0.
  - `rx_shift` holds; a partial frame is discarded.
  - `tx_shift` loads `data_out`.
  - `data_out` holds.
  - `miso` = 0.
- **Active** (`cs`=0), on each rising edge:
  - `rx_shift` <= {`rx_shift`[WIDTH-2:0], `mosi`}.
  - `tx_shift` <= {`tx_shift`[WIDTH-2:0], 1'b0}.
  - `bit_cnt` increments.
- **Frame complete**: on the edge where `bit_cnt` == WIDTH-1:
  - `data_out` <= {`rx_shift`[WIDTH-2:0], `mosi`}.
  - `bit_cnt` wraps to 0.
  - `tx_shift` reloads with that same new byte.
  - This supports back-to-back frames without raising `cs`.
- **`miso` output**: `miso` = `tx_shift`[WIDTH-1] when `cs`=0, else 0. No tristate.
- **State** is implied by `bit_cnt` and `cs`: IDLE (`cs`=1) and SHIFT(n), n = 0..WIDTH-1.
- **Transitions**:
  - SHIFT(WIDTH-1) goes to SHIFT(0).
  - `cs` rising in any state goes to IDLE.

## Timing
- The master changes `mosi` after a rising edge; the slave samples on the next rising edge.
- `cs` is sampled on the same rising edge as `mosi`. The first bit is captured on the first edge at which `cs`=0.
- `data_out` updates on the edge that samples bit 0 (the LSB). It is visible after that edge: latency 0 cycles after the last sampled bit.
- `data_out` is stable between frames and after `cs` deasserts.
- `miso`:
  - The MSB of the echo byte is present as soon as `cs`=0.
  - Each subsequent bit appears after each rising edge.
  - The first frame after reset echoes 0x00.
- Reset mid-frame: the partial frame is lost, `data_out` goes to 0, and the next frame starts from bit 7 when `cs`=0.
- `cs` high for a single edge mid-frame: the counter resets and the partial frame is lost.

## Structure
- No package needed.
- `WIDTH` is the only constant.
- Single module. An optional sub-module `spi_shift_reg` (WIDTH, load, shift, serial in/out) can be used for both the rx and tx paths.

## Test plan
- Reset with `cs`=1: `data_out`=0x00 and `miso`=0 on the edge after `rst`.
- Drive 0xBD (1011_1101) MSB-first over 8 edges with `cs`=0, then raise `cs` → `data_out`=0xBD on the 8th edge, not earlier, and it holds after `cs` rises.
- Send 0xBD then 0x3C back-to-back with `cs` held low → `data_out`=0xBD after edge 8 and 0x3C after edge 16. `miso` during the second frame = 1,0,1,1,1,1,0,1.
- Send 5 bits, raise `cs`, then send 0xA5 → `data_out`=0xA5 with no corruption from the partial frame.
- Send 0xFF, then assert `rst` mid-way through sending 0x00 → `data_out`=0x00 after reset, and the next full frame 0x81 gives `data_out`=0x81.
- Send 0x5A, then a second frame → `miso` bits = 0,1,0,1,1,0,1,0. `miso`=0 whenever `cs`=1.

Source files
------------

// File: rtl/spi_slave_byte_pkg.sv
// Shared constants and helpers for the byte-oriented SPI receive slave.
package spi_slave_byte_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-counter width able to hold 0..w-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_byte_shift_reg.sv
// Parallel-load / serial-shift register used for both the rx and tx paths.
module spi_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Load has priority over shift so a frame boundary reloads cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (shift_i) begin
            q_q <= {q_q[WIDTH-2:0], sin_i};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 receive slave on the bus clock: MSB-first capture, echo of the last byte on miso.
module spi_slave_byte
    import spi_slave_byte_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rx_q, tx_q, rx_next, tx_load_val;
    logic             frame_done, tx_load;

    assign rx_next    = {rx_q[WIDTH-2:0], mosi};
    assign frame_done = !cs && (bit_cnt_q == CNT_W'(WIDTH - 1));

    // Counter and published byte; the completed frame is visible on the same edge.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        if (cs) begin
            bit_cnt_d = '0;
        end else if (frame_done) begin
            bit_cnt_d = '0;
            data_d    = rx_next;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
        end
    end

    spi_shift_reg #(.WIDTH(WIDTH)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (!cs),
        .sin_i      (mosi),
        .q_o        (rx_q)
    );

    // Idle reloads the echo from data_out; a completed frame reloads with the new byte.
    assign tx_load     = cs || frame_done;
    assign tx_load_val = cs ? data_q : rx_next;

    spi_shift_reg #(.WIDTH(WIDTH)) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (tx_load_val),
        .shift_i    (!cs),
        .sin_i      (1'b0),
        .q_o        (tx_q)
    );

    assign miso     = !cs && tx_q[WIDTH-1];
    assign data_out = data_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: directed plan plus randomized traffic against a frame model.
module tb_spi_slave_byte;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    spi_slave_byte #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Frame-level model: bits collected since the frame began, last published byte, byte being echoed.
    int   m_n = 0;
    int   m_cur = 0;
    int   m_data = 0;
    int   m_echo = 0;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0; m_cur = 0; m_data = 0; m_echo = 0; m_live = 1'b1;
        end else if (cs) begin
            m_n = 0; m_cur = 0; m_echo = m_data;
        end else begin
            m_cur = ((m_cur * 2) + int'(mosi)) % 256;
            m_n   = m_n + 1;
            if (m_n == 8) begin
                m_data = m_cur; m_echo = m_cur; m_n = 0; m_cur = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("model data_out", int'(data_out), m_data);
            check("model miso", int'(miso), cs ? 0 : ((m_echo >> (7 - m_n)) & 1));
        end
    end

    logic pre_miso;

    // Apply inputs for the next rising edge, note miso, then return just after that edge.
    task automatic step(input logic r, input logic c, input logic m);
        rst = r; cs = c; mosi = m;
        #1 pre_miso = miso;
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] echo);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b0, b[i]);
            echo[i] = pre_miso;
        end
    endtask

    logic [7:0] echo;

    initial begin
        @(posedge clk); #2;
        step(1'b1, 1'b1, 1'b0);
        check("reset data_out", int'(data_out), 8'h00);
        check("reset miso", int'(miso), 0);

        // 0xBD: not visible after 7 bits, visible after the 8th, held after cs rises.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 1; i--) begin
            logic [7:0] bd;
            bd = 8'hBD;
            step(1'b0, 1'b0, bd[i]);
        end
        check("bd early", int'(data_out), 8'h00);
        step(1'b0, 1'b0, 1'b1);
        check("bd 8th edge", int'(data_out), 8'hBD);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("bd hold", int'(data_out), 8'hBD);

        // Back-to-back 0xBD, 0x3C.
        send_byte(8'hBD, echo);
        check("b2b first", int'(data_out), 8'hBD);
        send_byte(8'h3C, echo);
        check("b2b second", int'(data_out), 8'h3C);
        check("b2b echo", int'(echo), 8'hBD);
        step(1'b0, 1'b1, 1'b0);

        // Partial frame discarded.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("partial hold", int'(data_out), 8'h3C);
        send_byte(8'hA5, echo);
        check("after partial", int'(data_out), 8'hA5);
        step(1'b0, 1'b1, 1'b0);

        // Reset mid-frame.
        send_byte(8'hFF, echo);
        check("ff frame", int'(data_out), 8'hFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("mid reset data_out", int'(data_out), 8'h00);
        send_byte(8'h81, echo);
        check("after reset frame", int'(data_out), 8'h81);
        check("after reset echo", int'(echo), 8'h00);
        step(1'b0, 1'b1, 1'b0);

        // Echo of 0x5A during the next frame.
        send_byte(8'h5A, echo);
        step(1'b0, 1'b1, 1'b0);
        check("idle miso", int'(miso), 0);
        send_byte(8'h00, echo);
        check("5a echo", int'(echo), 8'h5A);
        check("zero frame", int'(data_out), 8'h00);
        step(1'b0, 1'b1, 1'b0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            logic r, c, m;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 19) == 0);
            m = 1'($urandom);
            step(r, c, m);
        end

        step(1'b0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
